logic_unit_seq: RTL and testbench

//  Parametrised multi-cycle bitwise logic unit; successor to the fixed 32-bit NOR block.

---
 rtl/logic_unit_seq_if.sv | 20 ++
 rtl/logic_unit_seq.sv | 81 ++++++++
 tb/tb_logic_unit_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_seq_if.sv
// logic_unit_seq_if: start/done handshake bundle for the sliced logic unit
//   start  request, accepted only when busy==0
//   op     3-bit function select, sampled with start
//   A, B   WIDTH-bit operands, sampled with start
//   busy   computation in progress
//   done   one-cycle pulse when F and zero become valid
//   F      registered result of the last completed operation
//   zero   1 when F == 0
interface logic_unit_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] F;
    logic             zero;
    modport master (output start, op, A, B, input busy, done, F, zero);
    modport slave  (input start, op, A, B, output busy, done, F, zero);
endinterface

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle bitwise logic unit, SLICE result bits per cycle
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    logic_unit_seq_if slave: start/op/A/B in, busy/done/F/zero out
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input logic clk,
    input logic reset,
    logic_unit_seq_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r, b_r, work, work_nxt, f_r;
    logic [2:0]       op_r;
    logic [SLICE-1:0] sa, sb, res;
    logic             zero_r, last, accept;

    assign last   = cnt == CW'(N - 1);
    // DONE accepts a new start just like IDLE, giving back-to-back runs
    assign accept = bus.start && state != RUN;
    assign sa     = a_r[cnt*SLICE +: SLICE];
    assign sb     = b_r[cnt*SLICE +: SLICE];

    always_comb begin
        res = op_r == 3'b000 ? sa & sb :
              op_r == 3'b001 ? sa | sb :
              op_r == 3'b010 ? sa ^ sb :
              op_r == 3'b011 ? ~(sa | sb) :
              op_r == 3'b100 ? ~(sa & sb) :
              op_r == 3'b101 ? ~(sa ^ sb) :
              op_r == 3'b110 ? sa & ~sb : ~sa;
        work_nxt = work;
        work_nxt[cnt*SLICE +: SLICE] = res;
    end

    always_comb begin
        state_nxt = IDLE;
        state_nxt = state == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            work   <= '0;
            f_r    <= '0;
            zero_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_r  <= bus.A;
                b_r  <= bus.B;
                op_r <= bus.op;
                cnt  <= '0;
            end else if (state == RUN) begin
                work <= work_nxt;
                if (last) begin
                    f_r    <= work_nxt;
                    zero_r <= work_nxt == '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.F    = f_r;
    assign bus.zero = zero_r;
endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: scoreboard bench for logic_unit_seq (32/8 and 16/16 instances)
module tb_logic_unit_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic_unit_seq_if #(.WIDTH(32)) b32();
    logic_unit_seq_if #(.WIDTH(16)) b16();

    logic_unit_seq #(.WIDTH(32), .SLICE(8))  dut   (.clk(clk), .reset(reset), .bus(b32));
    logic_unit_seq #(.WIDTH(16), .SLICE(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return ~(a & b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return ~a;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        b32.start = 1'b1;
        b32.op = op;
        b32.A = a;
        b32.B = b;
        if (push) exp_q.push_back(model(op, a, b));
        cyc();
        b32.start = 1'b0;
        b32.op = 3'($urandom);
        b32.A = $urandom;
        b32.B = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!b32.done && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (b32.done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", b32.done, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        checks += 4;
        if (b32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b32.busy); end
        if (b32.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", b32.done); end
        if (b32.F !== 32'h0) begin errors++; $display("FAIL reset_F: got %h want 0", b32.F); end
        if (b32.zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", b32.zero); end
    endtask

    task automatic test_nor();
        int n;
        logic [31:0] e;
        issue(3'b011, 32'h0, 32'h0, 1);
        checks++;
        if (b32.busy !== 1'b1) begin errors++; $display("FAIL nor_busy: got %b want 1", b32.busy); end
        wait_done(n);
        e = exp_q.pop_front();
        checks += 4;
        if (n != 4) begin errors++; $display("FAIL nor_latency: got %0d want 4", n); end
        if (b32.busy !== 1'b0) begin errors++; $display("FAIL nor_busy_done: got %b want 0", b32.busy); end
        if (b32.F !== e) begin errors++; $display("FAIL nor_F: got %h want %h", b32.F, e); end
        if (b32.zero !== 1'b0) begin errors++; $display("FAIL nor_zero: got %b want 0", b32.zero); end
        cyc();
        checks++;
        if (b32.done !== 1'b0) begin errors++; $display("FAIL nor_done_width: got %b want 0", b32.done); end
    endtask

    task automatic test_and_zero();
        int n;
        logic [31:0] e;
        issue(3'b000, 32'hF0F0F0F0, 32'h0F0F0F0F, 1);
        wait_done(n);
        e = exp_q.pop_front();
        checks += 2;
        if (b32.F !== e) begin errors++; $display("FAIL and_F: got %h want %h", b32.F, e); end
        if (b32.zero !== 1'b1) begin errors++; $display("FAIL and_zero: got %b want 1", b32.zero); end
        cyc();
        checks += 2;
        if (b32.done !== 1'b0) begin errors++; $display("FAIL and_done_width: got %b want 0", b32.done); end
        if (b32.F !== e) begin errors++; $display("FAIL and_F_hold: got %h want %h", b32.F, e); end
    endtask

    task automatic test_ignore_start();
        int n;
        logic [31:0] e;
        issue(3'b000, 32'hFFFF0000, 32'hFF00FF00, 1);
        cyc();
        b32.start = 1'b1;
        b32.A = 32'h12345678;
        b32.B = 32'h0;
        b32.op = 3'b001;
        cyc();
        b32.start = 1'b0;
        checks++;
        if (b32.busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", b32.busy); end
        wait_done(n);
        e = exp_q.pop_front();
        checks += 2;
        if (n != 2) begin errors++; $display("FAIL ign_latency: got %0d want 2", n); end
        if (b32.F !== e) begin errors++; $display("FAIL ign_F: got %h want %h", b32.F, e); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] e;
        issue(3'b001, 32'h000000F0, 32'h0F000000, 1);
        wait_done(n);
        e = exp_q.pop_front();
        checks++;
        if (b32.F !== e) begin errors++; $display("FAIL b2b_first_F: got %h want %h", b32.F, e); end
        issue(3'b010, 32'hAAAA5555, 32'hFFFF0000, 1);
        checks += 2;
        if (b32.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", b32.busy); end
        if (b32.F !== e) begin errors++; $display("FAIL b2b_F_hold: got %h want %h", b32.F, e); end
        wait_done(n);
        e = exp_q.pop_front();
        checks += 3;
        if (n + 1 != 5) begin errors++; $display("FAIL b2b_latency: got %0d want 5", n + 1); end
        if (b32.F !== 32'h55555555) begin errors++; $display("FAIL b2b_F_const: got %h want 55555555", b32.F); end
        if (b32.F !== e) begin errors++; $display("FAIL b2b_F: got %h want %h", b32.F, e); end
        cyc();
    endtask

    task automatic test_reset_abort();
        int n;
        int seen;
        logic [31:0] e;
        issue(3'b011, 32'h0, 32'h0, 0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks += 4;
        if (b32.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", b32.busy); end
        if (b32.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", b32.done); end
        if (b32.F !== 32'h0) begin errors++; $display("FAIL abort_F: got %h want 0", b32.F); end
        if (b32.zero !== 1'b0) begin errors++; $display("FAIL abort_zero: got %b want 0", b32.zero); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (b32.done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        issue(3'b100, 32'hFFFFFFFF, 32'h0000FFFF, 1);
        wait_done(n);
        e = exp_q.pop_front();
        checks += 3;
        if (n != 4) begin errors++; $display("FAIL post_abort_latency: got %0d want 4", n); end
        if (b32.F !== e) begin errors++; $display("FAIL post_abort_F: got %h want %h", b32.F, e); end
        if (b32.zero !== 1'b0) begin errors++; $display("FAIL post_abort_zero: got %b want 0", b32.zero); end
        cyc();
    endtask

    task automatic test_all_ops();
        int n;
        logic [31:0] e, a, b;
        for (int k = 0; k < 9; k++) begin
            a = (k == 8) ? 32'hFFFFFFFF : $urandom;
            b = $urandom;
            issue(3'(k), a, b, 1);
            wait_done(n);
            e = exp_q.pop_front();
            checks += 2;
            if (b32.F !== e) begin errors++; $display("FAIL op%0d_F: got %h want %h", k % 8, b32.F, e); end
            if (b32.zero !== (e == 32'h0)) begin errors++; $display("FAIL op%0d_zero: got %b want %b", k % 8, b32.zero, e == 32'h0); end
            cyc();
        end
    endtask

    task automatic test_single_slice();
        int n;
        b16.start = 1'b1;
        b16.op = 3'b110;
        b16.A = 16'hFF00;
        b16.B = 16'h0F0F;
        cyc();
        b16.start = 1'b0;
        b16.A = 16'h0;
        b16.B = 16'h0;
        n = 0;
        while (!b16.done && n < 10) begin
            cyc();
            n++;
        end
        checks += 3;
        if (n != 1) begin errors++; $display("FAIL s16_latency: got %0d want 1", n); end
        if (b16.F !== 16'hF000) begin errors++; $display("FAIL s16_F: got %h want f000", b16.F); end
        if (b16.zero !== 1'b0) begin errors++; $display("FAIL s16_zero: got %b want 0", b16.zero); end
        cyc();
        checks++;
        if (b16.done !== 1'b0) begin errors++; $display("FAIL s16_done_width: got %b want 0", b16.done); end
    endtask

    initial begin
        b32.start = 1'b0;
        b32.op = 3'b0;
        b32.A = '0;
        b32.B = '0;
        b16.start = 1'b0;
        b16.op = 3'b0;
        b16.A = '0;
        b16.B = '0;
        test_reset();
        test_nor();
        test_and_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_all_ops();
        test_single_slice();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
